// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single data-memory port between the CPU MEM stage and a camera
//   pixel writer. The owner is decided combinationally every cycle, so a
//   granted CPU access sees zero added latency. Camera bursts are capped at
//   BURST_MAX cycles while the CPU is requesting. A camera kept waiting for
//   WAIT_MAX cycles is forced through.
//
//   Ports
//     clock, reset_n              system clock (rising edge), async active-low reset
//     cpu_req/we/addr/wdata       CPU access request
//     cpu_rdata, cpu_stall        read data to the MEM stage, hold request
//     cam_req/addr/wdata          camera pixel-word write request
//     cam_ack                     camera word written this cycle
//     mem_addr/wdata/we           data-memory port drive
//     mem_rdata                   data-memory combinational read data
//     grant_cam                   camera owns the port this cycle
module mem_port_arbiter #(
    parameter int unsigned BURST_MAX = 4,
    parameter int unsigned WAIT_MAX  = 8
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        cam_req,
    input  logic [31:0] cam_addr,
    input  logic [31:0] cam_wdata,
    output logic        cam_ack,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata,
    output logic        grant_cam
);

    localparam int unsigned BW = $clog2(BURST_MAX + 1);
    localparam int unsigned WW = $clog2(WAIT_MAX + 1);
    localparam logic [BW-1:0] BMAX = BW'(BURST_MAX);
    localparam logic [WW-1:0] WMAX = WW'(WAIT_MAX);

    typedef enum logic [1:0] {IDLE, CPU, CAM} state_t;

    state_t        state;
    state_t        owner;
    logic [BW-1:0] burst_cnt;
    logic [WW-1:0] wait_cnt;

    // Reset gates the owner directly so the port is released the moment
    // reset_n falls, not at the next clock edge.
    always_comb begin
        owner = IDLE;
        if (!reset_n)
            owner = IDLE;
        else if (state == CAM && cam_req && burst_cnt < BMAX)
            owner = CAM;
        else if (cam_req && wait_cnt == WMAX)
            owner = CAM;
        else if (cpu_req)
            owner = CPU;
        else if (cam_req)
            owner = CAM;
    end

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        cpu_rdata = '0;
        cam_ack   = 1'b0;
        grant_cam = 1'b0;
        case (owner)
            CPU: begin
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                mem_we    = cpu_we;
                cpu_rdata = mem_rdata;
            end
            CAM: begin
                mem_addr  = cam_addr;
                mem_wdata = cam_wdata;
                mem_we    = 1'b1;
                cam_ack   = 1'b1;
                grant_cam = 1'b1;
            end
            default: ;
        endcase
        cpu_stall = cpu_req && (owner != CPU);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            burst_cnt <= '0;
            wait_cnt  <= '0;
        end else begin
            state <= owner;

            // A burst that already hit the cap but keeps the port (no CPU
            // contention) starts counting a new burst from 1.
            if (owner != CAM)
                burst_cnt <= '0;
            else if (burst_cnt == BMAX)
                burst_cnt <= BW'(1);
            else
                burst_cnt <= burst_cnt + BW'(1);

            if (owner == CAM || !cam_req)
                wait_cnt <= '0;
            else if (wait_cnt != WMAX)
                wait_cnt <= wait_cnt + WW'(1);
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int BM = 4;
    localparam int WM = 8;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        cpu_req, cpu_we, cam_req, cam_ack, cpu_stall, mem_we, grant_cam;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, cam_addr, cam_wdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clock = ~clock;

    mem_port_arbiter #(.BURST_MAX(BM), .WAIT_MAX(WM)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .cam_req   (cam_req),
        .cam_addr  (cam_addr),
        .cam_wdata (cam_wdata),
        .cam_ack   (cam_ack),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .grant_cam (grant_cam)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: owner codes 0 = none, 1 = CPU, 2 = camera.
    int m_prev;   // owner of the previous cycle
    int m_run;    // camera cycles in the current burst
    int m_waited; // cycles the pending camera word has been refused

    function automatic int ref_owner();
        if (!reset_n)                                return 0;
        if (m_prev == 2 && cam_req && m_run < BM)    return 2;
        if (cam_req && m_waited == WM)               return 2;
        if (cpu_req)                                 return 1;
        if (cam_req)                                 return 2;
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: inputs already driven; check mid-cycle, then advance
    // the model across the rising edge. exp_owner < 0 skips directed checks.
    task automatic step(input int exp_owner, input bit chk_rd = 1'b0,
                        input logic [31:0] exp_rd = '0);
        int own;
        @(negedge clock);
        if (!reset_n) begin
            m_prev = 0; m_run = 0; m_waited = 0;
        end
        own = ref_owner();
        chk("mem_addr",  mem_addr,  own == 1 ? cpu_addr  : own == 2 ? cam_addr  : 32'h0);
        chk("mem_wdata", mem_wdata, own == 1 ? cpu_wdata : own == 2 ? cam_wdata : 32'h0);
        chk("mem_we",    32'(mem_we),    32'(own == 1 ? cpu_we : own == 2));
        chk("cpu_rdata", cpu_rdata, own == 1 ? mem_rdata : 32'h0);
        chk("cpu_stall", 32'(cpu_stall), 32'(cpu_req && own != 1));
        chk("cam_ack",   32'(cam_ack),   32'(own == 2));
        chk("grant_cam", 32'(grant_cam), 32'(own == 2));
        if (exp_owner >= 0) begin
            chk("dir_grant", 32'(grant_cam), 32'(exp_owner == 2));
            chk("dir_stall", 32'(cpu_stall), 32'(cpu_req && exp_owner != 1));
            if (exp_owner == 0) chk("dir_we_none", 32'(mem_we), 32'h0);
            if (exp_owner == 1) chk("dir_addr_cpu", mem_addr, cpu_addr);
            if (exp_owner == 2) chk("dir_we_cam", 32'(mem_we), 32'h1);
        end
        if (chk_rd) chk("dir_rdata", cpu_rdata, exp_rd);
        @(posedge clock);
        if (!reset_n) begin
            m_prev = 0; m_run = 0; m_waited = 0;
        end else begin
            m_prev   = own;
            m_run    = (own == 2) ? ((m_run == BM) ? 1 : m_run + 1) : 0;
            m_waited = (own == 2 || !cam_req) ? 0 : ((m_waited < WM) ? m_waited + 1 : WM);
        end
        #1;
    endtask

    task automatic idle();
        cpu_req = 1'b0; cam_req = 1'b0; cpu_we = 1'b0;
        step(0);
    endtask

    initial begin
        m_prev = 0; m_run = 0; m_waited = 0;
        reset_n   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = 32'h0000_0040;
        cpu_wdata = 32'h1111_2222;
        cam_addr  = 32'h8000_0000;
        cam_wdata = 32'hCAFE_0001;
        mem_rdata = 32'h1234_5678;

        // Reset with both requesting: port idle, CPU stalled.
        cpu_req = 1'b1; cam_req = 1'b1;
        step(0, 1'b1, 32'h0);
        reset_n = 1'b1;
        step(1);
        idle();

        // CPU read: same-cycle data return.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100; mem_rdata = 32'hDEAD_BEEF;
        step(1, 1'b1, 32'hDEAD_BEEF);
        idle();

        // Camera burst capped while CPU waits (CPU requests in cycles 2-4).
        cam_req = 1'b1;
        for (int c = 0; c < 6; c++) begin
            cpu_req   = (c >= 2 && c <= 4);
            cam_wdata = 32'hCA00_0000 + 32'(c);
            step((c == 4) ? 1 : 2);
        end
        idle();

        // CPU hogging: camera forced through after WAIT_MAX cycles.
        cpu_req = 1'b1; cam_req = 1'b1; cpu_addr = 32'h200;
        for (int c = 0; c < 13; c++)
            step((c >= 8 && c <= 11) ? 2 : 1);
        idle();

        // Simultaneous first requests from IDLE: CPU write first, camera next.
        cpu_req = 1'b1; cam_req = 1'b1; cpu_we = 1'b1; cpu_wdata = 32'h5;
        step(1);
        cpu_req = 1'b0; cpu_we = 1'b0;
        step(2);
        idle();

        // Reset in the middle of a burst, then a fresh 4-cycle burst.
        cam_req = 1'b1;
        step(2);
        step(2);
        reset_n = 1'b0;
        step(0);
        reset_n = 1'b1;
        step(2);
        cpu_req = 1'b1;
        step(2);
        step(2);
        step(2);
        step(1);
        idle();

        // Randomized traffic against the model.
        for (int c = 0; c < 600; c++) begin
            reset_n   = ($urandom_range(0, 59) != 0);
            cpu_req   = ($urandom_range(0, 2) != 0);
            cpu_we    = $urandom_range(0, 1) != 0;
            cam_req   = $urandom_range(0, 1) != 0;
            cpu_addr  = $urandom;
            cpu_wdata = $urandom;
            cam_addr  = $urandom;
            cam_wdata = $urandom;
            mem_rdata = $urandom;
            step(-1);
        end
        reset_n = 1'b1;

        // Uncontended camera stream: burst count wraps, port kept.
        cpu_req = 1'b0; cam_req = 1'b1;
        for (int c = 0; c < 10; c++) step(2);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter BURST_MAX, default 4: maximum consecutive camera-owned cycles while the CPU is requesting.
REQ-002 Parameter WAIT_MAX, default 8: camera wait-cycle count that forces a camera grant.
REQ-003 clock  in  1  single system clock, rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 cpu_req  in  1  MEM stage needs the data-memory port this cycle.
REQ-006 cpu_we  in  1  CPU access is a write.
REQ-007 cpu_addr  in  32  CPU byte address (ALU result of the MEM stage).
REQ-008 cpu_wdata  in  32  CPU store data (post plus-one select).
REQ-009 cpu_rdata  out  32  read data returned to the MEM stage.
REQ-010 cpu_stall  out  1  MEM stage must hold this cycle.
REQ-011 cam_req  in  1  camera has one pixel word pending.
REQ-012 cam_addr  in  32  camera frame-buffer address.
REQ-013 cam_wdata  in  32  camera pixel word.
REQ-014 cam_ack  out  1  camera word written this cycle.
REQ-015 mem_addr, mem_wdata  out  32 each  data-memory address and write data.
REQ-016 mem_we  out  1  data-memory write enable.
REQ-017 mem_rdata  in  32  data-memory combinational read data.
REQ-018 grant_cam  out  1  camera owns the port this cycle.

Function
REQ-019 Registered state SHALL be one of IDLE, CPU, CAM; next state equals this cycle's owner (none -> IDLE).
REQ-020 Owner SHALL be decided combinationally, first match wins: (a) state==CAM, cam_req, burst_cnt<BURST_MAX -> CAM; (b) cam_req, wait_cnt==WAIT_MAX -> CAM; (c) cpu_req -> CPU; (d) cam_req -> CAM; (e) none.
REQ-021 burst_cnt SHALL increment on each CAM-owned cycle, clear when owner!=CAM, and restart at 1 when CAM-owned with burst_cnt==BURST_MAX.
REQ-022 wait_cnt SHALL increment, saturating at WAIT_MAX, when cam_req and owner!=CAM; clear when owner==CAM or cam_req==0.
REQ-023 Owner CPU: mem_addr=cpu_addr, mem_wdata=cpu_wdata, mem_we=cpu_we, cpu_rdata=mem_rdata, same cycle (zero added latency).
REQ-024 Owner CAM: mem_addr=cam_addr, mem_wdata=cam_wdata, mem_we=1, cam_ack=1, grant_cam=1.
REQ-025 Owner none: mem_addr, mem_wdata, mem_we, cpu_rdata all 0.
REQ-026 cpu_rdata SHALL be 0 whenever owner!=CPU.
REQ-027 cpu_stall = cpu_req AND owner!=CPU; the CPU SHALL hold address/data stable while stalled.
REQ-028 cam_ack SHALL never assert without cam_req; camera holds its word until acked.
REQ-029 Simultaneous first requests from IDLE: CPU wins unless wait_cnt==WAIT_MAX.
REQ-030 cam_req dropping mid-burst SHALL end the burst that cycle; CPU granted if requesting.

Reset
REQ-031 reset_n low SHALL immediately force state IDLE, burst_cnt=0, wait_cnt=0, owner none: mem_we=0, cam_ack=0, grant_cam=0, cpu_rdata=0, cpu_stall=cpu_req.
REQ-032 Reset asserted mid-burst SHALL abort the burst; no write completes in that cycle; first post-reset cycle arbitrates from IDLE.

Verification
REQ-033 reset_n=0, cpu_req=cam_req=1 -> mem_we=0, cam_ack=0, cpu_stall=1; release -> first cycle owner CPU, cpu_stall=0.
REQ-034 CPU read only, cpu_addr=0x100, mem_rdata=0xDEADBEEF -> mem_addr=0x100, mem_we=0, cpu_rdata=0xDEADBEEF, cpu_stall=0 same cycle.
REQ-035 cam_req held from cycle 0, cpu_req pulses cycles 2-4 -> cam_ack cycles 0-3, cpu_stall cycles 2-3, CPU owns cycle 4, cam_ack resumes cycle 5.
REQ-036 cpu_req held continuously, cam_req from cycle 0 -> CPU owns 0-7, cam_ack cycles 8-11, cpu_stall 8-11, CPU owns cycle 12.
REQ-037 Both requests rise together from IDLE, cpu_we=1, cpu_wdata=0x5 -> CPU write 0x5 that cycle, camera acked next cycle.
REQ-038 reset_n pulsed low during cycle 2 of a camera burst -> mem_we=0 during reset, burst_cnt=0, post-reset camera burst starts a fresh 4-cycle count.
